// File: rtl/writeback.sv
// Purpose : final pipeline stage; owns the 32x32 register file and the PC, retires one instruction per commit.
// Latency : commit seen in IDLE -> register/PC update one cycle later -> pc_valid pulse two cycles after commit.
// Backpres: commit is level-held; WAIT_LOW ignores it until it drops, so a held commit retires exactly once.
//
// Ports   : clk/rst (sync, active-high); memory_i_* commit + load data; execute_i_* ALU result and redirect;
//           decode_i_* pc/rd/wb_sel of the current instruction plus two read addresses;
//           writeback_o_rdata1/2 combinational reads, writeback_o_pc/pc_valid next fetch PC, writeback_o_busy.
// Option  : define WRITEBACK_INSTRET_EN to add parameter INSTRET_W and the writeback_o_instret retire counter.
module writeback #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
`ifdef WRITEBACK_INSTRET_EN
    ,
    parameter int INSTRET_W = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_i_commit,
    input  logic [31:0] memory_i_valM,
    input  logic [31:0] execute_i_valE,
    input  logic        execute_i_branch_taken,
    input  logic [31:0] execute_i_branch_target,
    input  logic [31:0] decode_i_pc,
    input  logic [4:0]  decode_i_rd,
    input  logic [1:0]  decode_i_wb_sel,
    input  logic [4:0]  decode_i_rs1,
    input  logic [4:0]  decode_i_rs2,
    output logic [31:0] writeback_o_rdata1,
    output logic [31:0] writeback_o_rdata2,
    output logic [31:0] writeback_o_pc,
    output logic        writeback_o_pc_valid,
    output logic        writeback_o_busy
`ifdef WRITEBACK_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] writeback_o_instret
`endif
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [1:0] WAIT_LOW = 2'd3;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_VALE = 2'b01;
    localparam logic [1:0] SEL_VALM = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Snapshot of the instruction taken on the commit edge; later input changes cannot disturb it.
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [31:0] val_e_q, val_e_d;
    logic [31:0] val_m_q, val_m_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;

    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] pc_plus4;

    assign pc_plus4 = inst_pc_q + 32'd4;
    assign wr_en    = (state_q == WRITE) && (wb_sel_q != SEL_NONE) && (rd_q != 5'd0);

    always_comb begin
        case (wb_sel_q)
            SEL_VALE: wr_data = val_e_q;
            SEL_VALM: wr_data = val_m_q;
            default:  wr_data = pc_plus4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        wb_sel_d  = wb_sel_q;
        val_e_d   = val_e_q;
        val_m_d   = val_m_q;
        inst_pc_d = inst_pc_q;
        taken_d   = taken_q;
        target_d  = target_q;
        case (state_q)
            IDLE: begin
                if (memory_i_commit) begin
                    state_d   = WRITE;
                    rd_d      = decode_i_rd;
                    wb_sel_d  = decode_i_wb_sel;
                    val_e_d   = execute_i_valE;
                    val_m_d   = memory_i_valM;
                    inst_pc_d = decode_i_pc;
                    taken_d   = execute_i_branch_taken;
                    target_d  = execute_i_branch_target;
                end
            end
            WRITE: begin
                state_d = DONE;
                pc_d    = taken_q ? target_q : pc_plus4;
            end
            DONE:     state_d = memory_i_commit ? WAIT_LOW : IDLE;
            default:  if (!memory_i_commit) state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[rd_q] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            rd_q      <= '0;
            wb_sel_q  <= '0;
            val_e_q   <= '0;
            val_m_q   <= '0;
            inst_pc_q <= '0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            wb_sel_q  <= wb_sel_d;
            val_e_q   <= val_e_d;
            val_m_q   <= val_m_d;
            inst_pc_q <= inst_pc_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
            regs_q    <= regs_d;
        end
    end

    // Reads bypass the write landing this cycle so decode never sees a stale value.
    always_comb begin
        if (decode_i_rs1 == 5'd0)                  writeback_o_rdata1 = '0;
        else if (wr_en && decode_i_rs1 == rd_q)    writeback_o_rdata1 = wr_data;
        else                                       writeback_o_rdata1 = regs_q[decode_i_rs1];
        if (decode_i_rs2 == 5'd0)                  writeback_o_rdata2 = '0;
        else if (wr_en && decode_i_rs2 == rd_q)    writeback_o_rdata2 = wr_data;
        else                                       writeback_o_rdata2 = regs_q[decode_i_rs2];
    end

    assign writeback_o_pc       = pc_q;
    assign writeback_o_pc_valid = (state_q == DONE);
    assign writeback_o_busy     = (state_q != IDLE);

`ifdef WRITEBACK_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    // Counts every WRITE cycle, including instructions that write nothing.
    always_comb begin
        instret_d = instret_q;
        if (state_q == WRITE) instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) instret_q <= '0;
        else     instret_q <= instret_d;
    end

    assign writeback_o_instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit;
    logic [31:0] val_m, val_e, target, ipc;
    logic        taken;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  sel;
    logic [31:0] rdata1, rdata2, o_pc;
    logic        pc_valid, busy;
`ifdef WRITEBACK_INSTRET_EN
    logic [63:0] instret;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: architectural registers, fetch PC and retire count.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [63:0] m_instret;

    always #5 clk = ~clk;

    writeback dut (
        .clk                     (clk),
        .rst                     (rst),
        .memory_i_commit         (commit),
        .memory_i_valM           (val_m),
        .execute_i_valE          (val_e),
        .execute_i_branch_taken  (taken),
        .execute_i_branch_target (target),
        .decode_i_pc             (ipc),
        .decode_i_rd             (rd),
        .decode_i_wb_sel         (sel),
        .decode_i_rs1            (rs1),
        .decode_i_rs2            (rs2),
        .writeback_o_rdata1      (rdata1),
        .writeback_o_rdata2      (rdata2),
        .writeback_o_pc          (o_pc),
        .writeback_o_pc_valid    (pc_valid),
        .writeback_o_busy        (busy)
`ifdef WRITEBACK_INSTRET_EN
        ,
        .writeback_o_instret     (instret)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc      = 32'h8000_0000;
        m_instret = 64'd0;
    endtask

    task automatic check_instret(input string name);
`ifdef WRITEBACK_INSTRET_EN
        total++;
        if (instret !== m_instret) begin
            bad++;
            $display("FAIL %s instret got=%0d want=%0d", name, instret, m_instret);
        end
`else
        if (name.len() == 0) $display("unnamed instret check");
`endif
    endtask

    // One instruction: commit held for 'hold' cycles, inputs scrambled after the latching edge.
    task automatic retire(input string name, input logic [4:0] a_rd, input logic [1:0] a_sel,
                          input logic [31:0] a_ve, input logic [31:0] a_vm, input logic [31:0] a_pc,
                          input logic a_tk, input logic [31:0] a_tg, input int hold);
        logic        wr;
        logic [31:0] data, new_pc, e1, e2;
        logic [4:0]  r2;
        logic        exp_busy;
        int          pulses, last_c;
        wr = (a_rd != 5'd0) && (a_sel != 2'b00);
        case (a_sel)
            2'b01:   data = a_ve;
            2'b10:   data = a_vm;
            2'b11:   data = a_pc + 32'd4;
            default: data = 32'd0;
        endcase
        new_pc = a_tk ? a_tg : a_pc + 32'd4;
        r2 = 5'($urandom);
        @(posedge clk); #1;
        rd = a_rd; sel = a_sel; val_e = a_ve; val_m = a_vm; ipc = a_pc;
        taken = a_tk; target = a_tg; commit = 1'b1; rs1 = a_rd; rs2 = r2;
        pulses = 0;
        last_c = ((hold > 2) ? hold : 2) + 2;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (pc_valid === 1'b1) pulses++;
            total++;
            if (pc_valid !== (c == 2)) begin
                bad++;
                $display("FAIL %s pc_valid cycle %0d got=%b want=%b", name, c, pc_valid, (c == 2));
            end
            exp_busy = (c == 1) || (c == 2) || (c >= 3 && c - 1 < hold);
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy cycle %0d got=%b want=%b", name, c, busy, exp_busy);
            end
            if (c == 1) begin
                e1 = (a_rd == 5'd0) ? 32'd0 : (wr ? data : m_regs[a_rd]);
                e2 = (r2 == 5'd0) ? 32'd0 : ((wr && r2 == a_rd) ? data : m_regs[r2]);
                total++;
                if (rdata1 !== e1) begin
                    bad++;
                    $display("FAIL %s bypass rdata1 got=%h want=%h", name, rdata1, e1);
                end
                total++;
                if (rdata2 !== e2) begin
                    bad++;
                    $display("FAIL %s bypass rdata2 got=%h want=%h", name, rdata2, e2);
                end
            end
            if (c == 2) begin
                total++;
                if (o_pc !== new_pc) begin
                    bad++;
                    $display("FAIL %s pc got=%h want=%h", name, o_pc, new_pc);
                end
            end
            @(posedge clk); #1;
            if (c + 1 >= hold) commit = 1'b0;
            if (c == 0) begin
                rd = 5'($urandom); sel = 2'($urandom); val_e = $urandom; val_m = $urandom;
                ipc = $urandom; taken = 1'($urandom); target = $urandom;
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL %s pc_valid pulses got=%0d want=1", name, pulses);
        end
        if (wr) m_regs[a_rd] = data;
        m_pc = new_pc;
        m_instret = m_instret + 64'd1;
        @(negedge clk);
        total++;
        if (rdata1 !== ((a_rd == 5'd0) ? 32'd0 : m_regs[a_rd])) begin
            bad++;
            $display("FAIL %s reg x%0d got=%h want=%h", name, a_rd, rdata1, m_regs[a_rd]);
        end
        total++;
        if (o_pc !== m_pc) begin
            bad++;
            $display("FAIL %s final pc got=%h want=%h", name, o_pc, m_pc);
        end
        check_instret(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; commit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (o_pc !== 32'h8000_0000) begin bad++; $display("FAIL reset pc got=%h want=80000000", o_pc); end
        total++;
        if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset pc_valid got=%b want=0", pc_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        check_instret("reset");
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            total++;
            if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
                bad++;
                $display("FAIL reset regs x%0d got=%h/%h want=0", i, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_alu();
        retire("alu", 5'd5, 2'b01, 32'h1234_5678, 32'h0, 32'h8000_0000, 1'b0, 32'h0, 5);
    endtask

    task automatic test_load_bypass();
        retire("load", 5'd7, 2'b10, 32'h5555_5555, 32'hFFFF_FF80, 32'h8000_0004, 1'b0, 32'h0, 2);
    endtask

    task automatic test_jump_link();
        retire("jal", 5'd1, 2'b11, 32'h0, 32'h0, 32'h8000_0010, 1'b1, 32'h8000_0100, 1);
    endtask

    task automatic test_x0_wrap();
        retire("x0", 5'd0, 2'b01, 32'hDEAD_BEEF, 32'h0, 32'h8000_0100, 1'b0, 32'h0, 3);
        retire("wrap", 5'd9, 2'b01, 32'h0000_0042, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h1234_0000, 1);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        rd = 5'd3; sel = 2'b01; val_e = 32'd9; ipc = 32'h8000_0020; taken = 1'b0; commit = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; commit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        rs1 = 5'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (pc_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid state cycle %0d pc_valid=%b busy=%b want 0/0", c, pc_valid, busy);
            end
        end
        total++;
        if (rdata1 !== 32'd0) begin bad++; $display("FAIL reset_mid x3 got=%h want=0", rdata1); end
        total++;
        if (o_pc !== 32'h8000_0000) begin bad++; $display("FAIL reset_mid pc got=%h want=80000000", o_pc); end
        check_instret("reset_mid");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            retire("random", 5'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), $urandom, $urandom_range(1, 5));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            retire("b2b", 5'($urandom_range(1, 31)), 2'b01, $urandom, 32'h0, m_pc, 1'b0, 32'h0, 1);
        end
    endtask

    initial begin
        rst = 1'b1; commit = 1'b0; val_m = '0; val_e = '0; target = '0; ipc = '0;
        taken = 1'b0; rd = '0; rs1 = '0; rs2 = '0; sel = '0;
        model_reset();
        test_reset();
        test_alu();
        test_load_bypass();
        test_jump_link();
        test_x0_wrap();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
